// File: rtl/dvp_pkg.sv
// Shared DVP link definitions: receiver FSM states and default frame geometry.
package dvp_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_VSYNC = 2'd1,
    S_FRAME = 2'd2
  } dvp_state_e;

  // Default geometry, shared with the DVP imitator
  localparam int DVP_H_BYTES = 2560;
  localparam int DVP_V_LINES = 720;

endpackage

// File: rtl/dvp_capture_rx_if.sv
// Camera pin bundle plus the captured pixel stream with line/frame markers.
interface dvp_capture_rx_if;
  logic        VSYNC;
  logic        HREF;
  logic [7:0]  D;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_sof;
  logic        pix_sol;
  logic        pix_eol;
  logic        pix_eof;

  // Camera / imitator side: drives pins, consumes pixels
  modport master (
    output VSYNC, HREF, D,
    input  pix_valid, pix_data, pix_sof, pix_sol, pix_eol, pix_eof
  );

  // Receiver side
  modport slave (
    input  VSYNC, HREF, D,
    output pix_valid, pix_data, pix_sof, pix_sol, pix_eol, pix_eof
  );
endinterface

// File: rtl/dvp_in_sampler.sv
// Registers the DVP pins once and derives VSYNC/HREF edges from a second stage.
module dvp_in_sampler (
  input  logic       pclk,
  input  logic       reset,
  input  logic       VSYNC,
  input  logic       HREF,
  input  logic [7:0] D,
  output logic       hr_r,
  output logic [7:0] d_r,
  output logic       vs_rise,
  output logic       vs_fall,
  output logic       hr_fall
);
  logic vs_r, vs_rr, hr_rr;

  // Pin capture plus one delayed copy of the sync lines for edge detect
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      vs_r  <= 1'b0;
      vs_rr <= 1'b0;
      hr_r  <= 1'b0;
      hr_rr <= 1'b0;
      d_r   <= 8'h00;
    end else begin
      vs_r  <= VSYNC;
      vs_rr <= vs_r;
      hr_r  <= HREF;
      hr_rr <= hr_r;
      d_r   <= D;
    end
  end

  assign vs_rise = vs_r & ~vs_rr;
  assign vs_fall = ~vs_r & vs_rr;
  assign hr_fall = ~hr_r & hr_rr;

endmodule

// File: rtl/dvp_capture_rx.sv
// DVP receiver: frame FSM, byte-pair packer with line/frame markers, and
// per-line / per-frame geometry checker.
module dvp_capture_rx
  import dvp_pkg::*;
#(
  parameter int H_BYTES = DVP_H_BYTES,
  parameter int V_LINES = DVP_V_LINES,
  parameter int LINE_W  = 12,
  parameter int ROW_W   = 10
) (
  input  logic             pclk,
  input  logic             reset,
  dvp_capture_rx_if.slave  bus,
  input  logic             capture_en,
  input  logic             err_clr,
  output logic [7:0]       frame_cnt,
  output logic             err_line,
  output logic             err_frame,
  output logic             busy
);
  localparam logic [LINE_W-1:0] H_END  = LINE_W'(H_BYTES);
  localparam logic [LINE_W-1:0] H_LAST = LINE_W'(H_BYTES - 1);
  localparam logic [LINE_W-1:0] B_ONE  = LINE_W'(1);
  localparam logic [ROW_W-1:0]  V_LAST = ROW_W'(V_LINES - 1);

  logic       hr_r, vs_rise, vs_fall, hr_fall;
  logic [7:0] d_r;

  dvp_in_sampler u_smp (
    .pclk    (pclk),
    .reset   (reset),
    .VSYNC   (bus.VSYNC),
    .HREF    (bus.HREF),
    .D       (bus.D),
    .hr_r    (hr_r),
    .d_r     (d_r),
    .vs_rise (vs_rise),
    .vs_fall (vs_fall),
    .hr_fall (hr_fall)
  );

  dvp_state_e        state, state_nx;
  logic [LINE_W-1:0] bcnt;
  logic              ovf;      // bytes arrived after the counter stopped at H_BYTES
  logic [ROW_W-1:0]  row;
  logic [7:0]        hi_byte;

  logic in_frame, abort, line_end, last_line, line_bad;

  // A VSYNC rise inside a frame wins over anything else happening that cycle
  assign in_frame  = (state == S_FRAME);
  assign abort     = in_frame && vs_rise;
  assign line_end  = in_frame && hr_fall && !vs_rise;
  assign last_line = (row == V_LAST);
  assign line_bad  = (bcnt != H_END) || ovf;
  assign busy      = (state != S_IDLE);

  // State register
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state: arm on VSYNC rise, start on VSYNC fall, finish after V_LINES lines
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (vs_rise && capture_en) state_nx = S_VSYNC;
      S_VSYNC: if (vs_fall) state_nx = S_FRAME;
      S_FRAME: begin
        if (abort)                      state_nx = capture_en ? S_VSYNC : S_IDLE;
        else if (line_end && last_line) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Byte counter and packer; even byte is held, odd byte completes a pixel
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      bcnt          <= '0;
      ovf           <= 1'b0;
      hi_byte       <= 8'h00;
      bus.pix_valid <= 1'b0;
      bus.pix_data  <= 16'h0000;
      bus.pix_sof   <= 1'b0;
      bus.pix_sol   <= 1'b0;
      bus.pix_eol   <= 1'b0;
      bus.pix_eof   <= 1'b0;
    end else begin
      bus.pix_valid <= 1'b0;
      bus.pix_sof   <= 1'b0;
      bus.pix_sol   <= 1'b0;
      bus.pix_eol   <= 1'b0;
      bus.pix_eof   <= 1'b0;
      if (!in_frame || abort || line_end) begin
        bcnt <= '0;
        ovf  <= 1'b0;
      end else if (hr_r) begin
        if (bcnt != H_END) begin
          bcnt <= bcnt + B_ONE;
          if (!bcnt[0]) begin
            hi_byte <= d_r;
          end else begin
            bus.pix_valid <= 1'b1;
            bus.pix_data  <= {hi_byte, d_r};
            bus.pix_sol   <= (bcnt == B_ONE);
            bus.pix_eol   <= (bcnt == H_LAST);
            bus.pix_sof   <= (bcnt == B_ONE) && (row == '0);
            bus.pix_eof   <= (bcnt == H_LAST) && last_line;
          end
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

  // Row counter, good-frame counter and sticky geometry errors (set beats clear)
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      row       <= '0;
      frame_cnt <= 8'h00;
      err_line  <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      if (state == S_VSYNC) row <= '0;
      else if (line_end)    row <= row + 1'b1;
      if (line_end && last_line) frame_cnt <= frame_cnt + 8'd1;
      if (line_end && line_bad) err_line <= 1'b1;
      else if (err_clr)         err_line <= 1'b0;
      if (abort)        err_frame <= 1'b1;
      else if (err_clr) err_frame <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dvp_capture_rx.sv
// Bench for dvp_capture_rx: scenario-level model of frames/lines producing an
// expected pixel queue (data, markers, arrival cycle) plus counter/flag state.
module tb_dvp_capture_rx;
  localparam int H = 8;
  localparam int V = 4;

  logic       pclk = 1'b0;
  logic       reset = 1'b0;
  logic       capture_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] frame_cnt;
  logic       err_line, err_frame, busy;

  dvp_capture_rx_if bus();

  dvp_capture_rx #(.H_BYTES(H), .V_LINES(V), .LINE_W(12), .ROW_W(10)) dut (
    .pclk       (pclk),
    .reset      (reset),
    .bus        (bus),
    .capture_en (capture_en),
    .err_clr    (err_clr),
    .frame_cnt  (frame_cnt),
    .err_line   (err_line),
    .err_frame  (err_frame),
    .busy       (busy)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  flags;   // {sof, sol, eol, eof}
    int          cyc;
  } pix_t;

  pix_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // model state
  bit         m_cap;
  int         m_row;
  logic [7:0] m_fc;
  bit         m_el, m_ef;
  logic [7:0] nb;

  // observed-stream statistics
  int          pix_cnt;
  logic [15:0] first_d, last_d;
  logic [3:0]  first_f, last_f;
  bit          prev_v = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {bus.pix_valid, bus.pix_data, bus.pix_sof, bus.pix_sol, bus.pix_eol,
            bus.pix_eof, frame_cnt, err_line, err_frame, busy};
  endfunction

  // Every cycle: a strobe must match the head of the expected queue at its
  // due cycle; an overdue expectation with no strobe is a missing pixel.
  always @(negedge pclk) begin : cmp
    pix_t       e;
    logic [3:0] f;
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      f = {bus.pix_sof, bus.pix_sol, bus.pix_eol, bus.pix_eof};
      if (bus.pix_valid) begin
        chk("pix_back_to_back", {31'd0, prev_v}, 32'd0);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pix_unexpected actual=%h/%b expected none", bus.pix_data, f);
        end else begin
          e = expq.pop_front();
          chk("pix_data", {16'd0, bus.pix_data}, {16'd0, e.data});
          chk("pix_flags", {28'd0, f}, {28'd0, e.flags});
          chk("pix_cycle", cyc, e.cyc);
        end
        if (pix_cnt == 0) begin
          first_d = bus.pix_data;
          first_f = f;
        end
        last_d = bus.pix_data;
        last_f = f;
        pix_cnt++;
      end else if (expq.size() != 0 && expq[0].cyc <= cyc) begin
        e = expq.pop_front();
        checks++;
        errors++;
        $display("FAIL pix_missing actual=none expected=%h/%b", e.data, e.flags);
      end
      prev_v = bus.pix_valid;
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      tick();
      bus.HREF = 1'b0;
      bus.D    = 8'($urandom);
    end
  endtask

  task automatic stats_clear();
    pix_cnt = 0;
    first_d = '0; last_d = '0; first_f = '0; last_f = '0;
  endtask

  task automatic model_clear();
    expq.delete();
    m_cap = 0; m_row = 0; m_fc = 8'd0; m_el = 0; m_ef = 0; nb = 8'd0;
    stats_clear();
  endtask

  task automatic apply_reset();
    tick();
    reset = 1'b1;
    bus.VSYNC = 1'b0; bus.HREF = 1'b0; bus.D = 8'h00;
    capture_en = 1'b0; err_clr = 1'b0;
    model_clear();
    idle(3);
    reset = 1'b0;
    idle(2);
  endtask

  // VSYNC pulse: aborts a capture in progress, re-arms from capture_en
  task automatic vsync_pulse();
    if (m_cap) m_ef = 1;
    m_cap = capture_en;
    m_row = 0;
    tick(); bus.HREF = 1'b0; bus.VSYNC = 1'b1;
    tick();
    tick(); bus.VSYNC = 1'b0;
    idle(3);
  endtask

  // One HREF line of n bytes; hold=1 leaves HREF high with the line unfinished
  task automatic send_line(int n, bit seq, bit hold);
    logic [7:0] b, hi;
    pix_t       e;
    hi = 8'h00;
    for (int i = 0; i < n; i++) begin
      tick();
      b = seq ? nb : 8'($urandom);
      if (seq) nb++;
      bus.HREF = 1'b1;
      bus.D    = b;
      if (m_cap && i < H && i[0]) begin
        e.data  = {hi, b};
        e.flags = {(i == 1) && (m_row == 0), i == 1, i == H - 1, (i == H - 1) && (m_row == V - 1)};
        e.cyc   = cyc + 2;
        expq.push_back(e);
      end
      hi = b;
    end
    if (!hold) begin
      tick();
      bus.HREF = 1'b0;
      if (m_cap) begin
        if (n != H) m_el = 1;
        m_row++;
        if (m_row == V) begin
          m_fc++;
          m_cap = 0;
        end
      end
      idle($urandom_range(0, 2));
    end
  endtask

  task automatic clear_pulse();
    tick(); err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    m_el = 0; m_ef = 0;
    idle(2);
  endtask

  task automatic end_check(string tag);
    idle(4);
    chk({tag, "_q_empty"}, expq.size(), 0);
    chk({tag, "_frame_cnt"}, {24'd0, frame_cnt}, {24'd0, m_fc});
    chk({tag, "_err_line"}, {31'd0, err_line}, {31'd0, m_el});
    chk({tag, "_err_frame"}, {31'd0, err_frame}, {31'd0, m_ef});
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int nl, n;
    bus.VSYNC = 1'b0; bus.HREF = 1'b0; bus.D = 8'h00;
    model_clear();
    #1 reset = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    chk("reset_outs", outs_vec(), 32'd0);
    reset = 1'b0;

    // nominal frame, sequential bytes 0x00..0x1F
    apply_reset();
    capture_en = 1'b1;
    vsync_pulse();
    for (int l = 0; l < V; l++) send_line(H, 1, 0);
    end_check("nom");
    chk("nom_pix_cnt", pix_cnt, 16);
    chk("nom_first", {12'd0, first_f, first_d}, {12'd0, 4'b1100, 16'h0001});
    chk("nom_last", {12'd0, last_f, last_d}, {12'd0, 4'b0011, 16'h1E1F});
    chk("nom_fc_lit", {24'd0, frame_cnt}, 32'd1);
    chk("nom_busy", {31'd0, busy}, 32'd0);

    // 6-byte line in row 2
    apply_reset();
    capture_en = 1'b1;
    vsync_pulse();
    send_line(H, 0, 0); send_line(H, 0, 0); send_line(6, 0, 0); send_line(H, 0, 0);
    end_check("short");
    chk("short_pix_cnt", pix_cnt, 15);
    chk("short_el_lit", {31'd0, err_line}, 32'd1);
    chk("short_fc_lit", {24'd0, frame_cnt}, 32'd1);

    // 7-byte line, then clear
    apply_reset();
    capture_en = 1'b1;
    vsync_pulse();
    send_line(H, 0, 0); send_line(7, 0, 0); send_line(H, 0, 0); send_line(H, 0, 0);
    end_check("odd");
    chk("odd_pix_cnt", pix_cnt, 15);
    chk("odd_el_lit", {31'd0, err_line}, 32'd1);
    clear_pulse();
    chk("odd_clr_lit", {31'd0, err_line}, 32'd0);
    end_check("odd_clr");

    // VSYNC after two lines aborts, then a full frame
    apply_reset();
    capture_en = 1'b1;
    vsync_pulse();
    send_line(H, 0, 0); send_line(H, 0, 0);
    vsync_pulse();
    end_check("abort");
    chk("abort_pix_cnt", pix_cnt, 8);
    chk("abort_last_flags", {28'd0, last_f}, 32'b0010);
    chk("abort_ef_lit", {31'd0, err_frame}, 32'd1);
    chk("abort_fc_lit", {24'd0, frame_cnt}, 32'd0);
    for (int l = 0; l < V; l++) send_line(H, 0, 0);
    end_check("abort_next");
    chk("abort_next_fc_lit", {24'd0, frame_cnt}, 32'd1);

    // capture disabled at VSYNC
    apply_reset();
    capture_en = 1'b0;
    vsync_pulse();
    chk("off_busy_vs", {31'd0, busy}, 32'd0);
    for (int l = 0; l < V; l++) send_line(H, 0, 0);
    end_check("off");
    chk("off_pix_cnt", pix_cnt, 0);
    chk("off_busy", {31'd0, busy}, 32'd0);

    // reset in the middle of a line
    apply_reset();
    capture_en = 1'b1;
    vsync_pulse();
    send_line(H, 0, 0); send_line(5, 0, 0); send_line(H, 0, 0); send_line(H, 0, 0);
    vsync_pulse();
    send_line(H, 0, 0);
    send_line(5, 0, 1);
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_outs", outs_vec(), 32'd0);
    model_clear();
    repeat (2) tick();
    reset = 1'b0;
    send_line(H, 0, 0); send_line(H, 0, 0);
    end_check("midrst");
    chk("midrst_pix_cnt", pix_cnt, 0);

    // randomized frames: capture_en, short/long lines, aborts, clears
    apply_reset();
    for (int f = 0; f < 14; f++) begin
      capture_en = ($urandom_range(0, 3) != 0);
      vsync_pulse();
      nl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, V - 1)) : V;
      for (int l = 0; l < nl; l++) begin
        n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, H + 3)) : H;
        send_line(n, 0, 0);
      end
      idle(3);
      if ($urandom_range(0, 3) == 0) clear_pulse();
      end_check("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
